// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Drives a 4-digit, common-anode, multiplexed seven-segment display from
//   four BCD digits. One digit is lit at a time for REFRESH_DIV clocks. The
//   digit values and decimal-point mask are captured once per frame, at the
//   end of digit 3, so a frame always shows one coherent value. Leading zeros
//   can optionally be blanked, and any non-BCD nibble is shown as a dash.
//
// Parameters
//   REFRESH_DIV   clk cycles each digit stays lit (>= 2)
//   BLANK_LEADING 1 = blank leading zeros, 0 = always show all four digits
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   en         1 = scan; 0 = hold scan state and blank the display
//   thousands  BCD digit 3 (most significant)
//   hundreds   BCD digit 2
//   tens       BCD digit 1
//   ones       BCD digit 0
//   dp_mask    bit k = 1 lights the decimal point on digit k
//   anode      active-low digit enables, bit k = digit k (registered)
//   segments   active-low segments {g,f,e,d,c,b,a} (registered)
//   dp         active-low decimal point (registered)

module seven_seg_scanner #(
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] thousands,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic [3:0] dp_mask,
   output logic [3:0] anode,
   output logic [6:0] segments,
   output logic       dp
);

   localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Active-low {g..a} pattern for one nibble; 10..15 render as a dash.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [CW-1:0]   div_cnt_q, div_cnt_d;
   logic [1:0]      idx_q,     idx_d;
   logic [3:0][3:0] lat_q,     lat_d;     // lat_q[k] = latched digit k
   logic [3:0]      lat_dp_q,  lat_dp_d;

   logic [3:0]      anode_q,   anode_d;
   logic [6:0]      seg_q,     seg_d;
   logic            dp_q,      dp_d;

   logic            tick;
   logic [3:0]      blank;
   logic [3:0]      cur_nib;

   assign tick = en && (div_cnt_q == CNT_LAST);

   // Leading-zero blanking works on the latched frame, so the blank pattern
   // is stable for a whole frame. Any non-BCD nibble is nonzero here and so
   // stops blanking of the digits below it. Digit 0 is never blanked.
   always_comb begin
      blank    = '0;
      blank[3] = BLANK_LEADING && (lat_q[3] == 4'd0);
      blank[2] = BLANK_LEADING && (lat_q[3] == 4'd0) && (lat_q[2] == 4'd0);
      blank[1] = BLANK_LEADING && (lat_q[3] == 4'd0) && (lat_q[2] == 4'd0)
                               && (lat_q[1] == 4'd0);
   end

   assign cur_nib = lat_q[idx_q];

   // ------------------------------------------------------------------
   // Scan counter, digit index and frame latch
   // ------------------------------------------------------------------
   always_comb begin
      div_cnt_d = div_cnt_q;
      idx_d     = idx_q;
      lat_d     = lat_q;
      lat_dp_d  = lat_dp_q;

      if (en) begin
         if (tick) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
            // Capture the next frame on the same edge that idx wraps to 0.
            if (idx_q == 2'd3) begin
               lat_d[3] = thousands;
               lat_d[2] = hundreds;
               lat_d[1] = tens;
               lat_d[0] = ones;
               lat_dp_d = dp_mask;
            end
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered display drive, one cycle behind the scan state
   // ------------------------------------------------------------------
   always_comb begin
      anode_d = '1;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;

      if (en) begin
         anode_d = ~(4'b0001 << idx_q);
         dp_d    = ~lat_dp_q[idx_q];
         // A blanked digit keeps its anode on; only the segments go dark.
         seg_d   = blank[idx_q] ? SEG_BLANK : decode(cur_nib);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q <= '0;
         idx_q     <= '0;
         lat_q     <= '0;
         lat_dp_q  <= '0;
         anode_q   <= '1;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
      end else begin
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         lat_q     <= lat_d;
         lat_dp_q  <= lat_dp_d;
         anode_q   <= anode_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign anode    = anode_q;
   assign segments = seg_q;
   assign dp       = dp_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Consumes the four BCD digits produced by the binary-to-BCD converter and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Time-multiplexes one digit at a time at a programmable refresh rate.
- Latches the BCD inputs once per frame so a digit cannot change partway through a frame.
- Optionally blanks leading zeros and shows a dash for any non-BCD nibble.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays lit (must be >= 2); counter width is $clog2(REFRESH_DIV)
BLANK_LEADING, 1, 1 = blank leading zeros; 0 = always show all four digits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = scan; 0 = freeze scan state and blank display
thousands  input  4  BCD digit 3 (most significant)
hundreds  input  4  BCD digit 2
tens  input  4  BCD digit 1
ones  input  4  BCD digit 0
dp_mask  input  4  bit k = 1 lights the decimal point on digit k
anode  output  4  active-low digit enables, bit k = digit k
segments  output  7  active-low segments, {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point

Behaviour:
- State registers:
  - div_cnt (0..REFRESH_DIV-1)
  - idx (2 bits, active digit)
  - lat[3:0] (four latched 4-bit digits)
  - lat_dp (4 bits)
- Reset (rst=1 at a rising edge):
  - div_cnt=0, idx=0, lat=all 0, lat_dp=0.
  - Outputs: anode=4'b1111, segments=7'b1111111, dp=1.
  - Reset wins over every other event, including mid-frame.
- tick = en & (div_cnt==REFRESH_DIV-1).
- When en=1:
  - div_cnt increments; it wraps to 0 on tick.
  - On tick, idx advances 0->1->2->3->0.
- Frame latch: on a tick with idx==3, lat and lat_dp are loaded from the inputs in the same edge that idx wraps to 0. Inputs are ignored at all other times.
- When en=0: div_cnt, idx and lat hold their values. The next registered outputs are anode=1111, segments=1111111, dp=1. When en returns to 1, scanning resumes from the held count.
- Outputs are registered with 1-cycle latency from (idx, lat, lat_dp, en):
  - anode = ~(4'b0001 << idx)
  - dp = ~lat_dp[idx]
  - segments = decode(lat[idx]) after blanking.
- Decode table (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = dash, 0111111 (only g lit)
- Leading-zero blanking (BLANK_LEADING=1), decided from latched values:
  - Digit 3 is blanked if lat3==0.
  - Digit 2 is blanked if lat3==0 and lat2==0.
  - Digit 1 is blanked if lat3, lat2 and lat1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit drives segments=1111111 but its anode is still asserted.
  - dp is independent of blanking.
  - A non-BCD nibble counts as nonzero for blanking purposes.
- Timing:
  - A full frame is 4*REFRESH_DIV cycles.
  - First frame after reset shows latched zeros, i.e. "   0" with blanking.
  - New inputs appear starting with digit 0 of the following frame.

Test Plan:
- REFRESH_DIV=4, rst for 2 cycles, then en=1 with inputs 1,2,3,4. Required:
  - Cycle after reset release: anode=1110, segments=1000000.
  - After 16 cycles, on the latch edge, lat updates.
  - Next frame: anode 1110/1101/1011/0111 shows 0011001, 0110000, 0100100, 1111001, each for 4 cycles.
- Inputs 0,0,4,2 with BLANK_LEADING=1. Required:
  - digit3 and digit2 segments=1111111 with anodes still asserted.
  - digit1=0011001, digit0=0100100.
  - With BLANK_LEADING=0, digits 3 and 2 show 1000000.
- Inputs 0,0,0,0 -> only digit0 shows 1000000; all others blank. Inputs with thousands=4'hC -> digit3 shows 0111111, and the lower zero digits are not blanked.
- Change the inputs in the middle of a frame (idx=1) -> displayed digits do not change until the frame wraps; dp_mask=0100 -> dp=0 only while anode=1011.
- Deassert en for 10 cycles mid-digit:
  - Next cycle anode=1111.
  - div_cnt and idx hold.
  - On re-enable, the same digit resumes and completes its remaining count.
- Assert rst mid-frame with idx=2 -> next cycle anode=1111 and segments=1111111; after release the scan restarts at digit 0 with lat=0.
